// File: rtl/note_display_scanner_if.sv
// Signal bundle between the note source, the display scanner and the segment decoder.
// note_on is a plain level with no valid/ready handshake; the scanner samples it every clock.
interface note_display_scanner_if;
    logic [2:0] note_in;
    logic       octave_hi;
    logic       note_on;
    logic [3:0] noteKey;
    logic [3:0] an;
    logic [1:0] digit_sel;
    logic [1:0] state_dbg;

    modport master (
        output note_in, octave_hi, note_on,
        input  noteKey, an, digit_sel, state_dbg
    );

    modport slave (
        input  note_in, octave_hi, note_on,
        output noteKey, an, digit_sel, state_dbg
    );
endinterface

// File: rtl/note_display_scanner.sv
// Latches the played note/octave, holds it for a number of frames after release, and
// scans it onto a 4-digit multiplexed display as <letter> <blank> H I / L O.
module note_display_scanner #(
    parameter int REFRESH_DIV = 100000,
    parameter int HOLD_SCANS  = 250
) (
    input logic                   clk,
    input logic                   rst,
    note_display_scanner_if.slave bus
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX    = CW'(REFRESH_DIV - 1);
    localparam logic [16:0]   HOLD_LIMIT = 17'(HOLD_SCANS);

    localparam logic [3:0] CODE_H     = 4'd5;
    localparam logic [3:0] CODE_L     = 4'd6;
    localparam logic [3:0] CODE_BLANK = 4'd7;
    localparam logic [3:0] CODE_I     = 4'd8;
    localparam logic [3:0] CODE_O     = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state_q, state_next;
    logic [2:0]    note_q, note_next;
    logic          oct_q, oct_next;
    logic [15:0]   frame_cnt_q, frame_cnt_next;
    logic [CW-1:0] refresh_cnt_q;
    logic [1:0]    digit_sel_q, digit_sel_next;
    logic [3:0]    an_q, an_next;
    logic [3:0]    key_q, key_next;
    logic          tick;
    logic          frame_tick;
    logic          note_valid;

    // An out-of-range note code is indistinguishable from a released key.
    assign note_valid = bus.note_on && (bus.note_in <= 3'd4);

    assign tick           = (refresh_cnt_q == CNT_MAX);
    assign frame_tick     = tick && (digit_sel_q == 2'd3);
    assign digit_sel_next = tick ? digit_sel_q + 2'd1 : digit_sel_q;
    assign an_next        = ~(4'b0001 << digit_sel_next);

    always_comb begin
        state_next     = state_q;
        note_next      = note_q;
        oct_next       = oct_q;
        frame_cnt_next = frame_cnt_q;
        case (state_q)
            IDLE: begin
                if (note_valid) begin
                    note_next  = bus.note_in;
                    oct_next   = bus.octave_hi;
                    state_next = SHOW;
                end
            end
            SHOW: begin
                if (note_valid) begin
                    note_next = bus.note_in;
                    oct_next  = bus.octave_hi;
                end else begin
                    state_next     = HOLD;
                    frame_cnt_next = 16'd0;
                end
            end
            HOLD: begin
                // A new key press wins over hold expiry on the same cycle.
                if (note_valid) begin
                    note_next  = bus.note_in;
                    oct_next   = bus.octave_hi;
                    state_next = SHOW;
                end else if (HOLD_LIMIT == 17'd0) begin
                    state_next = IDLE;
                end else if (frame_tick) begin
                    if (({1'b0, frame_cnt_q} + 17'd1) == HOLD_LIMIT) begin
                        state_next = IDLE;
                    end else begin
                        frame_cnt_next = frame_cnt_q + 16'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Code for the digit that becomes selected on this edge, so anode and code move together.
    always_comb begin
        key_next = CODE_BLANK;
        if (state_q != IDLE) begin
            case (digit_sel_next)
                2'd3:    key_next = {1'b0, note_q};
                2'd2:    key_next = CODE_BLANK;
                2'd1:    key_next = oct_q ? CODE_H : CODE_L;
                default: key_next = oct_q ? CODE_I : CODE_O;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt_q <= '0;
            digit_sel_q   <= 2'd0;
            an_q          <= 4'b1110;
            key_q         <= CODE_BLANK;
            state_q       <= IDLE;
            note_q        <= 3'd0;
            oct_q         <= 1'b0;
            frame_cnt_q   <= 16'd0;
        end else begin
            refresh_cnt_q <= tick ? '0 : refresh_cnt_q + CW'(1);
            digit_sel_q   <= digit_sel_next;
            an_q          <= an_next;
            key_q         <= key_next;
            state_q       <= state_next;
            note_q        <= note_next;
            oct_q         <= oct_next;
            frame_cnt_q   <= frame_cnt_next;
        end
    end

    assign bus.noteKey   = key_q;
    assign bus.an        = an_q;
    assign bus.digit_sel = digit_sel_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_note_display_scanner.sv
// Directed bench for note_display_scanner: one instance with a 2-frame hold, one with no hold.
module tb_note_display_scanner;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SHOW = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] note_in;
  logic       octave_hi;
  logic       note_on;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  note_display_scanner_if bus1 ();
  note_display_scanner_if bus2 ();

  assign bus1.note_in   = note_in;
  assign bus1.octave_hi = octave_hi;
  assign bus1.note_on   = note_on;
  assign bus2.note_in   = note_in;
  assign bus2.octave_hi = octave_hi;
  assign bus2.note_on   = note_on;

  note_display_scanner #(.REFRESH_DIV(4), .HOLD_SCANS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  note_display_scanner #(.REFRESH_DIV(4), .HOLD_SCANS(0)) dut_nohold (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_steps(input int n);
    repeat (n) step();
  endtask

  // scoreboard
  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Digit index follows from cycles since reset: REFRESH_DIV=4, so d = (cyc/4) % 4.
  task automatic check_cycles(input int n, input logic [3:0] c3, input logic [3:0] c2,
                              input logic [3:0] c1, input logic [3:0] c0);
    int d;
    logic [3:0] exp_key;
    logic [3:0] exp_an;
    for (int i = 0; i < n; i++) begin
      step();
      d = (cyc / 4) % 4;
      case (d)
        3:       exp_key = c3;
        2:       exp_key = c2;
        1:       exp_key = c1;
        default: exp_key = c0;
      endcase
      exp_an = ~(4'b0001 << d);
      chk4("an", bus1.an, exp_an);
      chk4("noteKey", bus1.noteKey, exp_key);
      chk2("digit_sel", bus1.digit_sel, 2'(d));
    end
  endtask

  initial begin
    rst       = 1'b1;
    note_in   = 3'd0;
    octave_hi = 1'b0;
    note_on   = 1'b0;

    // reset held two cycles
    step();
    chk4("reset_an", bus1.an, 4'b1110);
    chk4("reset_key", bus1.noteKey, 4'h7);
    step();
    chk4("reset_an2", bus1.an, 4'b1110);
    chk4("reset_key2", bus1.noteKey, 4'h7);
    chk2("reset_state", bus1.state_dbg, S_IDLE);
    rst = 1'b0;
    cyc = 0;

    // idle blank scan
    check_cycles(16, 4'h7, 4'h7, 4'h7, 4'h7);

    // G, high octave
    note_in = 3'd3; octave_hi = 1'b1; note_on = 1'b1;
    idle_steps(16);
    check_cycles(16, 4'h3, 4'h7, 4'h5, 4'h8);
    chk2("show_state", bus1.state_dbg, S_SHOW);

    // switch to low octave while held
    octave_hi = 1'b0;
    idle_steps(16);
    check_cycles(16, 4'h3, 4'h7, 4'h6, 4'h9);

    // release: two frames of hold, then blank
    note_on = 1'b0;
    check_cycles(16, 4'h3, 4'h7, 4'h6, 4'h9);
    chk2("hold_state", bus1.state_dbg, S_HOLD);
    check_cycles(16, 4'h3, 4'h7, 4'h6, 4'h9);
    chk2("expired_state", bus1.state_dbg, S_IDLE);
    check_cycles(16, 4'h7, 4'h7, 4'h7, 4'h7);

    // retrigger on the cycle of the second frame tick in HOLD
    note_in = 3'd3; octave_hi = 1'b1; note_on = 1'b1;
    idle_steps(16);
    note_on = 1'b0;
    check_cycles(31, 4'h3, 4'h7, 4'h5, 4'h8);
    note_in = 3'd0; note_on = 1'b1;
    check_cycles(17, 4'h0, 4'h7, 4'h5, 4'h8);
    chk2("retrigger_state", bus1.state_dbg, S_SHOW);

    // invalid note from SHOW acts as a release
    note_in = 3'd6;
    check_cycles(16, 4'h0, 4'h7, 4'h5, 4'h8);
    chk2("invalid_hold_state", bus1.state_dbg, S_HOLD);
    check_cycles(16, 4'h0, 4'h7, 4'h5, 4'h8);
    chk2("invalid_expire_state", bus1.state_dbg, S_IDLE);
    // invalid note from IDLE keeps the display blank
    check_cycles(32, 4'h7, 4'h7, 4'h7, 4'h7);
    chk2("invalid_idle_state", bus1.state_dbg, S_IDLE);

    // reset pulse during HOLD
    note_in = 3'd4; octave_hi = 1'b0; note_on = 1'b1;
    idle_steps(16);
    note_on = 1'b0;
    check_cycles(8, 4'h4, 4'h7, 4'h6, 4'h9);
    chk2("pre_reset_state", bus1.state_dbg, S_HOLD);
    rst = 1'b1;
    step();
    chk4("midhold_rst_an", bus1.an, 4'b1110);
    chk4("midhold_rst_key", bus1.noteKey, 4'h7);
    chk2("midhold_rst_sel", bus1.digit_sel, 2'd0);
    chk2("midhold_rst_state", bus1.state_dbg, S_IDLE);
    rst = 1'b0;
    cyc = 0;
    check_cycles(16, 4'h7, 4'h7, 4'h7, 4'h7);

    // zero-frame hold variant
    note_in = 3'd2; octave_hi = 1'b1; note_on = 1'b1;
    idle_steps(16);
    chk2("nohold_show_state", bus2.state_dbg, S_SHOW);
    chk4("nohold_show_key", bus2.noteKey, 4'h8);
    note_on = 1'b0;
    step();
    chk2("nohold_hold_state", bus2.state_dbg, S_HOLD);
    chk4("nohold_hold_key", bus2.noteKey, 4'h8);
    step();
    chk2("nohold_idle_state", bus2.state_dbg, S_IDLE);
    step();
    chk4("nohold_blank_key", bus2.noteKey, 4'h7);
    chk4("nohold_blank_an", bus2.an, 4'b1110);
    chk4("hold2_still_key", bus1.noteKey, 4'h8);
    chk2("hold2_still_state", bus1.state_dbg, S_HOLD);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
